// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and FSM encoding for the SPI LCD slave
package spi_pkg;
    localparam int SPI_BYTE_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_e;
endpackage

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - show-ahead received-byte FIFO, drops pushes when full
module spi_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         full_o,
    output logic         overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          do_pop, do_push;

    assign valid_o    = (count_q != '0);
    assign full_o     = (count_q == FULL_CNT);
    assign data_o     = mem_q[rd_ptr_q];
    assign overflow_o = overflow_q;

    // A simultaneous pop frees the head slot, so a full FIFO may still accept.
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop) count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
            if (push_i && !do_push) overflow_q <= 1'b1;
        end
    end
endmodule

// File: rtl/spi_lcd_slave.sv
// rtl/spi_lcd_slave.sv - SPI mode-0 slave receiving LCD bytes into a FIFO
// Optional miso echo of the previous frame's last byte: SPI_SLAVE_ECHO_EN.
module spi_lcd_slave
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_active,
    output logic [7:0]            byte_count,
    output logic                  frame_err,
    output logic                  overflow
);
    // Synchronizer chains reset low so a slave select held low through reset
    // never looks like a fresh falling edge.
    logic [2:0] sync_q [SYNC_STAGES];
    logic       ss_s, sclk_s, mosi_s;
    logic       ss_prev_q, sclk_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            ss_prev_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {ss, sclk, mosi};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            ss_prev_q   <= ss_s;
            sclk_prev_q <= sclk_s;
        end
    end

    assign {ss_s, sclk_s, mosi_s} = sync_q[SYNC_STAGES-1];

    logic ss_fall, ss_rise, sclk_rise;
    assign ss_fall   = ss_prev_q && !ss_s;
    assign ss_rise   = !ss_prev_q && ss_s;
    assign sclk_rise = !sclk_prev_q && sclk_s;

    spi_state_e            state_q;
    logic [SPI_BYTE_W-1:0] shift_q;
    logic [2:0]            bit_cnt_q;
    logic [7:0]            byte_count_q;
    logic                  frame_active_q, frame_err_q;
    logic [SPI_BYTE_W-1:0] byte_next;
    logic                  byte_done;

    assign byte_next = {shift_q[SPI_BYTE_W-2:0], mosi_s};
    assign byte_done = (state_q == SPI_ACTIVE) && !ss_rise && sclk_rise && (bit_cnt_q == 3'd7);

`ifdef SPI_SLAVE_ECHO_EN
    logic                  sclk_fall;
    logic [SPI_BYTE_W-1:0] last_byte_q, tx_shift_q;
    logic                  miso_q;
    assign sclk_fall = sclk_prev_q && !sclk_s;
    assign miso      = miso_q;
`else
    assign miso = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= SPI_IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            byte_count_q   <= '0;
            frame_active_q <= 1'b0;
            frame_err_q    <= 1'b0;
`ifdef SPI_SLAVE_ECHO_EN
            last_byte_q    <= '0;
            tx_shift_q     <= '0;
            miso_q         <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                SPI_IDLE: begin
                    if (ss_fall) begin
                        state_q        <= SPI_ACTIVE;
                        bit_cnt_q      <= '0;
                        byte_count_q   <= '0;
                        frame_active_q <= 1'b1;
`ifdef SPI_SLAVE_ECHO_EN
                        tx_shift_q     <= last_byte_q;
                        miso_q         <= last_byte_q[SPI_BYTE_W-1];
`endif
                    end
                end
                SPI_ACTIVE: begin
                    if (ss_rise) begin
                        state_q        <= SPI_IDLE;
                        frame_active_q <= 1'b0;
                        frame_err_q    <= (bit_cnt_q != 3'd0);
                        bit_cnt_q      <= '0;
`ifdef SPI_SLAVE_ECHO_EN
                        miso_q         <= 1'b0;
`endif
                    end else begin
                        if (sclk_rise) begin
                            shift_q   <= byte_next;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (byte_count_q != 8'hFF) byte_count_q <= byte_count_q + 8'd1;
`ifdef SPI_SLAVE_ECHO_EN
                                last_byte_q <= byte_next;
`endif
                            end
                        end
`ifdef SPI_SLAVE_ECHO_EN
                        if (sclk_fall) begin
                            tx_shift_q <= {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
                            miso_q     <= tx_shift_q[SPI_BYTE_W-2];
                        end
`endif
                    end
                end
                default: state_q <= SPI_IDLE;
            endcase
        end
    end

    assign frame_active = frame_active_q;
    assign byte_count   = byte_count_q;
    assign frame_err    = frame_err_q;

    logic fifo_full;

    spi_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SPI_BYTE_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (byte_done),
        .push_data_i (byte_next),
        .pop_i       (rx_ready),
        .data_o      (rx_data),
        .valid_o     (rx_valid),
        .full_o      (fifo_full),
        .overflow_o  (overflow)
    );
endmodule

// File: doc/spi_lcd_slave.md
Name: spi_lcd_slave

Overview:
- SPI mode-0 slave: the receiving end of the LCD SPI link driven by the display controller (ss/mosi/sclk/miso).
- Oversamples ss/sclk/mosi in the clk domain, assembles MSB-first bytes and buffers them in a small FIFO for a downstream consumer, such as a character-LCD model or a scoreboard.
- Used as an on-chip loopback target and as a bench model of the LCD module.

Parameters:
- FIFO_DEPTH, 4, received-byte buffer entries; power of 2, 2..16.
- SYNC_STAGES, 2, flip-flop synchronizer depth on ss, sclk and mosi; minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ss  in  1  SPI slave select, active low, asynchronous to clk.
- sclk  in  1  SPI clock, idle low; frequency ≤ clk/8.
- mosi  in  1  SPI data in.
- miso  out  1  SPI data out (see Optional Feature).
- rx_data  out  8  head-of-FIFO byte, show-ahead.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer pops the head when rx_valid && rx_ready.
- frame_active  out  1  high while the synchronized ss is low.
- byte_count  out  8  bytes completed in the current frame, saturates at 255.
- frame_err  out  1  one-cycle pulse when ss rises with a partial byte.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - miso=0, rx_data=0x00, rx_valid=0, frame_active=0, byte_count=0, frame_err=0, overflow=0.
  - FIFO flushed, shift register, bit counter and last-byte register cleared, FSM=IDLE.
- Input conditioning:
  - ss, sclk and mosi each pass through SYNC_STAGES flip-flops.
  - Edge detect compares the last synchronizer stage with one extra registered copy.
  - All decisions below use the synchronized signals only.
- FSM IDLE:
  - Entered from reset or when ss_s=1.
  - On ss_s falling: go to ACTIVE; bit_cnt←0, byte_count←0, frame_active←1 the same cycle.
- FSM ACTIVE:
  - On each sclk_s rising edge: shift_reg←{shift_reg[6:0], mosi_s}; bit_cnt←bit_cnt+1.
  - On the 8th rising edge (bit_cnt==7), in the same cycle:
    - the assembled byte {shift_reg[6:0], mosi_s} is pushed into the FIFO;
    - bit_cnt wraps to 0;
    - byte_count increments, saturating at 255.
  - On ss_s rising: go to IDLE, frame_active←0.
    - If bit_cnt≠0, frame_err pulses for 1 cycle and the partial bits are discarded.
    - byte_count holds its value until the next frame start.
  - An sclk_s edge in the same cycle as ss_s rising is ignored.
- Latency: the push happens in the cycle of the detected 8th edge; rx_valid and rx_data update the next cycle.
- FIFO:
  - rx_valid = !empty; rx_data = mem[rd_ptr], valid only while rx_valid=1.
  - Pop when rx_valid && rx_ready; pointers wrap modulo FIFO_DEPTH.
  - Full with no pop: the incoming byte is dropped and overflow←1. overflow clears only on rst.
  - Full with pop and push in the same cycle: both are accepted and occupancy is unchanged.
  - Empty with push: no pop is possible that cycle; rx_valid=1 the next cycle.
  - rx_ready while empty has no effect.
- Reset mid-frame or mid-byte: everything returns to its reset values.
  - The remainder of an ss-low frame after reset is received normally only after a fresh ss falling edge.
  - While ss_s is still low after reset, the FSM stays in IDLE.

Optional Feature:
- Macro SPI_SLAVE_ECHO_EN.
- Defined (echo on):
  - Each completed byte (pushed or dropped) is copied into last_byte.
  - On ss_s falling, tx_shift←last_byte and miso drives tx_shift[7].
  - On each sclk_s falling edge in ACTIVE, tx_shift shifts left and miso follows the new tx_shift[7] (mode 0).
  - miso=0 in IDLE.
- Undefined (echo off): miso is tied to 0 and the tx logic is absent.

Decomposition:
- Shared package spi_pkg:
  - SPI_BYTE_W=8;
  - FSM state encoding SPI_IDLE=1'b0, SPI_ACTIVE=1'b1;
  - SYNC_STAGES default.
- One natural sub-module: spi_rx_fifo (parameterized show-ahead FIFO with push, pop, full, empty, drop-on-full).
- Synchronizers and FSM stay in the top.

Test Plan:
- Frame ss↓, send 0xA5 at clk/16, ss↑ → rx_data=0xA5, rx_valid=1 exactly 1 clk after the 8th synchronized sclk rise; byte_count=1; frame_err=0.
- One frame of 0x01,0x02,0x03,0x04,0x05 with rx_ready=0 and FIFO_DEPTH=4 → FIFO holds 01..04; overflow=1; byte_count=5; then rx_ready=1 pops 01,02,03,04 and rx_valid drops.
- ss↑ after 5 bits → frame_err 1-cycle pulse, no push; the next frame with 0x3C delivers 0x3C.
- FIFO full with rx_ready=1 while a byte completes → pop and push in the same cycle; occupancy stays 4; overflow stays 0.
- rst asserted after 4 bits and then released while ss stays low → outputs at reset values; no byte produced until ss↑/ss↓ and a fresh 8 bits.
- SPI_SLAVE_ECHO_EN defined: send 0x5A, then in the next frame send 0x00 → miso shifts out 0,1,0,1,1,0,1,0 on the second frame.
